// File: rtl/sump_cmd_asm_pkg.sv
// ---------------------------------------------------------------------------
// sump_cmd_asm_pkg
// Shared declarations for the SUMP command assembler. It holds the command
// record handed to ctrl, the SUMP opcode constants, the bit that marks a long
// (5-byte) command, and the assembler state type.
// ---------------------------------------------------------------------------
package sump_cmd_asm_pkg;

    // One complete SUMP command: opcode plus 32-bit little-endian payload.
    typedef struct packed {
        logic [7:0]  opcode;
        logic [31:0] data;
    } cmd_t;

    // SUMP opcodes. Bit 7 set means four data bytes follow the opcode.
    localparam logic [7:0] OP_RESET          = 8'h00;
    localparam logic [7:0] OP_RUN            = 8'h01;
    localparam logic [7:0] OP_ID             = 8'h02;
    localparam logic [7:0] OP_XON            = 8'h11;
    localparam logic [7:0] OP_XOFF           = 8'h13;
    localparam logic [7:0] OP_SET_DIVIDER    = 8'h80;
    localparam logic [7:0] OP_SET_READ_DELAY = 8'h81;
    localparam logic [7:0] OP_SET_FLAGS      = 8'h82;

    localparam int CMD_LONG_BIT = 7;

    typedef enum logic {
        ST_IDLE,
        ST_COLLECT
    } state_t;

    // True when the opcode announces a 4-byte payload.
    function automatic logic is_long_cmd(input logic [7:0] opcode);
        return opcode[CMD_LONG_BIT];
    endfunction

endpackage

// File: rtl/sump_timeout_cnt.sv
// ---------------------------------------------------------------------------
// sump_timeout_cnt
// Idle-cycle counter with saturation. The count is cleared by clear_i, counts
// up on every enabled cycle without clear, and saturates at TIMEOUT_CYCLES-1.
// expired_o flags the enabled, uncleared cycle on which the count would reach
// TIMEOUT_CYCLES-1, so the owner can react on that same clock edge.
//
// Ports
//   clk_i      in  1  clock
//   rst_i      in  1  synchronous active-high reset
//   clear_i    in  1  restart the count (has priority over enable_i)
//   enable_i   in  1  count this cycle
//   expired_o  out 1  the (TIMEOUT_CYCLES-1)th consecutive enabled idle cycle
// ---------------------------------------------------------------------------
module sump_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up until saturation.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Once TIMEOUT_CYCLES-2 idle cycles have been counted, the current idle
    // cycle is the last one allowed.
    assign expired_o = enable_i && !clear_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/sump_cmd_asm.sv
// ---------------------------------------------------------------------------
// sump_cmd_asm
// Assembles SUMP command frames from the UART RX byte stream and hands each
// complete command to ctrl. Short commands (opcode bit 7 clear) are a single
// byte. Long commands are the opcode followed by four data bytes, with the
// first data byte landing in data[7:0]. A long frame that stalls is dropped
// once its idle timeout expires, and the next byte is then read as an opcode.
//
// Ports
//   clk_i          in  1   clock
//   rst_i          in  1   synchronous active-high reset
//   rx_data_i      in  8   received UART byte
//   rx_valid_i     in  1   rx_data_i valid strobe, may be high every cycle
//   cmd_o          out 40  {opcode, data} of the last completed command
//   exec_o         out 1   one-cycle strobe, cmd_o newly valid
//   busy_o         out 1   long frame partially received
//   err_timeout_o  out 1   one-cycle strobe, partial frame dropped
// ---------------------------------------------------------------------------
module sump_cmd_asm
    import sump_cmd_asm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic [39:0] cmd_o,
    output logic        exec_o,
    output logic        busy_o,
    output logic        err_timeout_o
);

    state_t     state_q,    state_d;
    logic [1:0] byte_cnt_q, byte_cnt_d;
    cmd_t       asm_q,      asm_d;
    cmd_t       cmd_q,      cmd_d;
    logic       exec_q,     exec_d;
    logic       err_q,      err_d;

    logic timeout_clear;
    logic timeout_enable;
    logic timeout_expired;

    // The counter runs only while collecting; any byte restarts it, which is
    // also why a byte arriving on the expiry cycle wins over the timeout.
    assign timeout_enable = (state_q == ST_COLLECT);
    assign timeout_clear  = (state_q != ST_COLLECT) || rx_valid_i;

    sump_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (timeout_clear),
        .enable_i (timeout_enable),
        .expired_o(timeout_expired)
    );

    // Frame decode: short opcodes complete immediately, long opcodes open a
    // frame that closes on the fourth data byte or on timeout.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        cmd_d      = cmd_q;
        exec_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid_i) begin
                    if (is_long_cmd(rx_data_i)) begin
                        asm_d.opcode = rx_data_i;
                        asm_d.data   = 32'h0;
                        byte_cnt_d   = 2'd0;
                        state_d      = ST_COLLECT;
                    end else begin
                        cmd_d.opcode = rx_data_i;
                        cmd_d.data   = 32'h0;
                        exec_d       = 1'b1;
                    end
                end
            end

            ST_COLLECT: begin
                if (rx_valid_i) begin
                    asm_d.data[{byte_cnt_q, 3'b000} +: 8] = rx_data_i;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        cmd_d   = asm_d;
                        exec_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (timeout_expired) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Reset drops any partial frame silently.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= 2'd0;
            asm_q      <= '0;
            cmd_q      <= '0;
            exec_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            cmd_q      <= cmd_d;
            exec_q     <= exec_d;
            err_q      <= err_d;
        end
    end

    assign cmd_o         = cmd_q;
    assign exec_o        = exec_q;
    assign err_timeout_o = err_q;
    assign busy_o        = (state_q == ST_COLLECT);

endmodule

// File: tb/tb_sump_cmd_asm.sv
// ---------------------------------------------------------------------------
// tb_sump_cmd_asm
// Bench for the SUMP command assembler, built with TIMEOUT_CYCLES=16.
// A frame-level model (queue of bytes of the open frame plus an idle count)
// predicts every output each cycle. Directed sequences pin concrete values
// and timings, and a randomized phase then mixes bytes, long gaps and resets.
// ---------------------------------------------------------------------------
module tb_sump_cmd_asm;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [39:0] cmd;
    logic        exec;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exec_seen = 0;
    int err_seen = 0;
    int last_valid_cyc = 0;
    int last_err_cyc = 0;

    // Model state: the bytes of the open long frame, idle cycles since the
    // last byte, and the outputs expected after the current edge.
    logic [7:0]  m_frame [$];
    bit          m_in_frame = 1'b0;
    int          m_idle = 0;
    logic [39:0] m_cmd = 40'h0;
    bit          m_exec = 1'b0;
    bit          m_err = 1'b0;

    int e0;
    int r0;

    always #5 clk = ~clk;

    sump_cmd_asm #(
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .rx_data_i    (rx_data),
        .rx_valid_i   (rx_valid),
        .cmd_o        (cmd),
        .exec_o       (exec),
        .busy_o       (busy),
        .err_timeout_o(err)
    );

    // Frame-level reference: a short opcode outside a frame completes at once,
    // five collected bytes complete a long command (payload little-endian),
    // and TIMEOUT-1 consecutive idle cycles inside a frame drop it.
    always @(posedge clk) begin
        cyc++;
        m_exec = 1'b0;
        m_err  = 1'b0;
        if (rst) begin
            m_in_frame = 1'b0;
            m_frame.delete();
            m_idle = 0;
            m_cmd  = 40'h0;
        end else if (rx_valid) begin
            last_valid_cyc = cyc;
            if (!m_in_frame && rx_data < 8'h80) begin
                m_cmd  = {rx_data, 32'h0};
                m_exec = 1'b1;
            end else begin
                m_frame.push_back(rx_data);
                m_in_frame = 1'b1;
                m_idle = 0;
                if (m_frame.size() == 5) begin
                    m_cmd = {m_frame[0], m_frame[4], m_frame[3], m_frame[2], m_frame[1]};
                    m_exec = 1'b1;
                    m_in_frame = 1'b0;
                    m_frame.delete();
                end
            end
        end else if (m_in_frame) begin
            m_idle++;
            if (m_idle == TIMEOUT - 1) begin
                m_err = 1'b1;
                m_in_frame = 1'b0;
                m_frame.delete();
            end
        end
    end

    // Every-cycle comparison against the model, sampled just after the edge,
    // plus strobe bookkeeping used by the directed checks.
    always @(posedge clk) begin
        #1;
        checks++;
        if (cmd !== m_cmd || exec !== m_exec || busy !== m_in_frame || err !== m_err) begin
            errors++;
            $display("[TB] FAIL cycle_compare cyc=%0d actual cmd=%h exec=%b busy=%b err=%b required cmd=%h exec=%b busy=%b err=%b",
                     cyc, cmd, exec, busy, err, m_cmd, m_exec, m_in_frame, m_err);
        end
        if (exec === 1'b1) exec_seen++;
        if (err === 1'b1) begin
            err_seen++;
            last_err_cyc = cyc;
        end
    end

    // One cycle of input, driven on the falling edge.
    task applyStimulus(input logic v, input logic [7:0] b);
        @(negedge clk);
        rx_valid = v;
        rx_data  = v ? b : 8'($urandom);
    endtask

    task idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 8'h00);
    endtask

    task checkOutput(input string name, input logic [39:0] actual, input logic [39:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    // Directed sequences followed by randomized traffic.
    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset_cmd", cmd, 40'h0);
        checkOutput("reset_flags", {37'b0, exec, busy, err}, 40'h0);
        rst = 1'b0;

        // Single short command.
        e0 = exec_seen; r0 = err_seen;
        applyStimulus(1'b1, 8'h01);
        applyStimulus(1'b0, 8'h00);
        checkOutput("t1_exec_next_cycle", {39'b0, exec}, 40'h1);
        idleCycles(2);
        checkOutput("t1_exec_count", 40'(exec_seen - e0), 40'd1);
        checkOutput("t1_cmd", cmd, 40'h01_00000000);

        // Long command with gaps between bytes.
        e0 = exec_seen;
        applyStimulus(1'b1, 8'hC0); idleCycles(2);
        checkOutput("t2_busy_mid", {39'b0, busy}, 40'h1);
        applyStimulus(1'b1, 8'h11); idleCycles(2);
        applyStimulus(1'b1, 8'h22); idleCycles(2);
        applyStimulus(1'b1, 8'h33); idleCycles(2);
        applyStimulus(1'b1, 8'h44); idleCycles(2);
        checkOutput("t2_exec_count", 40'(exec_seen - e0), 40'd1);
        checkOutput("t2_cmd", cmd, 40'hC0_44332211);
        checkOutput("t2_busy_after", {39'b0, busy}, 40'h0);

        // Stalled frame times out; command is kept, then resync on next byte.
        e0 = exec_seen; r0 = err_seen;
        applyStimulus(1'b1, 8'h80);
        applyStimulus(1'b1, 8'hAA);
        idleCycles(20);
        checkOutput("t3_err_count", 40'(err_seen - r0), 40'd1);
        checkOutput("t3_err_delay", 40'(last_err_cyc - last_valid_cyc), 40'd15);
        checkOutput("t3_no_exec", 40'(exec_seen - e0), 40'd0);
        checkOutput("t3_cmd_kept", cmd, 40'hC0_44332211);
        applyStimulus(1'b1, 8'h02);
        idleCycles(1);
        checkOutput("t3_resync_cmd", cmd, 40'h02_00000000);

        // Back-to-back short and long commands.
        e0 = exec_seen;
        repeat (5) applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'hC1);
        applyStimulus(1'b1, 8'h01);
        applyStimulus(1'b1, 8'h02);
        applyStimulus(1'b1, 8'h03);
        applyStimulus(1'b1, 8'h04);
        idleCycles(2);
        checkOutput("t4_exec_count", 40'(exec_seen - e0), 40'd6);
        checkOutput("t4_cmd", cmd, 40'hC1_04030201);

        // Byte on the expiry cycle is accepted.
        e0 = exec_seen; r0 = err_seen;
        applyStimulus(1'b1, 8'h81);
        applyStimulus(1'b1, 8'h55);
        idleCycles(TIMEOUT - 2);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'h66);
        applyStimulus(1'b1, 8'h77);
        idleCycles(2);
        checkOutput("t5_no_err", 40'(err_seen - r0), 40'd0);
        checkOutput("t5_exec_count", 40'(exec_seen - e0), 40'd1);
        checkOutput("t5_cmd", cmd, 40'h81_77660055);

        // Reset in the middle of a frame.
        e0 = exec_seen; r0 = err_seen;
        applyStimulus(1'b1, 8'hC0);
        applyStimulus(1'b1, 8'h11);
        @(negedge clk);
        rst = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        checkOutput("t6_reset_cmd", cmd, 40'h0);
        checkOutput("t6_reset_flags", {37'b0, exec, busy, err}, 40'h0);
        rst = 1'b0;
        applyStimulus(1'b1, 8'h01);
        idleCycles(20);
        checkOutput("t6_cmd", cmd, 40'h01_00000000);
        checkOutput("t6_exec_count", 40'(exec_seen - e0), 40'd1);
        checkOutput("t6_no_err", 40'(err_seen - r0), 40'd0);

        // Randomized traffic: dense bytes, occasional long gaps and resets.
        repeat (4000) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                @(negedge clk);
                rst = 1'b1;
                rx_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
            end else if (r < 6) begin
                idleCycles($urandom_range(TIMEOUT - 3, TIMEOUT + 2));
            end else if (r < 60) begin
                applyStimulus(1'b1, 8'($urandom));
            end else begin
                applyStimulus(1'b0, 8'h00);
            end
        end
        idleCycles(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
